instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//   Parametrised instruction memory plus fetch engine for the 5-stage RISC-V core (IF stage).
//   - Holds program words in a synchronous-read array.
//   - Fetches sequentially from a PC register and buffers {pc, instr, fault} in a prefetch FIFO.
//   - Hands entries to decode over a valid/ready handshake.
//   - Supports branch/jump redirect (flush) and a preload write port for benches and the boot loader.
// PARAMETERS
//   XLEN        32      address/PC width
//   MEM_WORDS   256     instruction words in the array (byte range 0 .. 4*MEM_WORDS-1)
//   FIFO_DEPTH  4       prefetch entries; power of 2, >= 2
//   RESET_PC    'h0     PC loaded on reset
// PORTS
//   clk            in   1     rising-edge clock
//   reset          in   1     synchronous, active-high reset
//   load_en        in   1     write load_data into the array this cycle
//   load_addr      in   XLEN  byte address of the write; bits[1:0] ignored, out-of-range ignored
//   load_data      in   32    instruction word to write
//   redirect_valid in   1     flush and restart fetch at redirect_pc
//   redirect_pc    in   XLEN  new fetch PC
//   out_valid      out  1     FIFO head is valid
//   out_ready      in   1     decode accepts the head this cycle
//   out_pc         out  XLEN  PC of the head entry
//   out_instr      out  32    instruction of the head entry
//   out_fault      out  1     head entry is misaligned or out of range
// BEHAVIOUR
//   Reset: pc=RESET_PC, FIFO empty, in-flight read cleared, state=FETCH.
//     - Outputs after reset: out_valid=0, out_pc=0, out_instr=0, out_fault=0.
//     - Array contents are NOT reset.
//   Array read: synchronous, 1-cycle latency.
//     - Address is sampled at edge N; data is pushed into the FIFO at edge N+1.
//     - out_valid is registered from the FIFO, so the first out_valid=1 is seen after the
//       2nd edge with reset=0.
//   Issue rule (state FETCH, no redirect): issue when (count - pop + inflight) < FIFO_DEPTH.
//     - pop = out_valid & out_ready.
//     - On issue: pc <= pc+4 (XLEN wrap).
//     - With out_ready held 1, throughput is 1 instr/cycle; no overflow ever occurs.
//   Fault: when pc[1:0]!=0 or pc >= 4*MEM_WORDS:
//     - Entry pushed with instr=32'h00000013 (NOP) and fault=1.
//     - State goes to HALT: no further issues.
//     - HALT is left only by redirect or reset.
//   Handshake:
//     - Head is held stable while out_valid & !out_ready.
//     - Pop and push in the same cycle keep count unchanged.
//   Redirect (highest priority after reset):
//     - At the edge: FIFO emptied, in-flight read discarded (not pushed), pc <= redirect_pc,
//       state=FETCH.
//     - out_valid=0 on the next cycle.
//     - A head popped in the redirect cycle counts as delivered.
//     - First redirected entry: out_valid=1 two edges after the redirect edge.
//   Preload:
//     - load_en writes array[load_addr[..:2]] at the edge; fetch is not stalled.
//     - Read and write of the same word in the same cycle returns OLD data.
//   Reset mid-operation: same as reset; the in-flight read is dropped.
//   Count width: $clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
// TESTING
//   1. Preload words 0..2 = 00000013, 00500093, 00108133; release reset, out_ready=1
//      -> (pc 0,4,8) delivered on consecutive cycles, fault=0; first out_valid after 2 edges.
//   2. Backpressure: out_ready=0 for 10 cycles
//      -> count saturates at 4, out_pc stays 0, no entries lost.
//      Then out_ready=1 -> pcs 0,4,8,12,... in order with no gaps.
//   3. Redirect to 'h20 while the FIFO holds 3 entries and a read is in flight
//      -> out_valid=0 next cycle; next delivered out_pc='h20, then 'h24; no stale PCs appear.
//   4. MEM_WORDS=256, redirect to 'h3FC
//      -> 'h3FC delivered fault=0; next entry pc='h400 with instr=00000013, fault=1;
//      no further out_valid until redirect.
//   5. Redirect to 'h6 -> single entry pc='h6, fault=1, then HALT.
//      Redirect to 'h0 -> normal fetch resumes.
//   6. load_en to 'h8 with 'hDEADBEEF in the cycle 'h8 is issued
//      -> delivered instr = old word; a later refetch of 'h8 returns DEADBEEF.
//      Assert reset mid-stream -> out_valid=0 the next cycle, then restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: array preload port, redirect request and the decode-side valid/ready head.
interface instr_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            load_en;
  logic [XLEN-1:0] load_addr;
  logic [31:0]     load_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            out_fault;

  modport master (
    output load_en, load_addr, load_data, redirect_valid, redirect_pc, out_ready,
    input  out_valid, out_pc, out_instr, out_fault
  );

  modport slave (
    input  load_en, load_addr, load_data, redirect_valid, redirect_pc, out_ready,
    output out_valid, out_pc, out_instr, out_fault
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// IF stage: synchronous-read instruction array, sequential PC fetch, prefetch FIFO to decode,
// redirect flush and a preload write port.
module instr_fetch_queue #(
  parameter int              XLEN       = 32,
  parameter int              MEM_WORDS  = 256,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input logic            clk,
  input logic            reset,
  instr_fetch_queue_if.slave bus
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN:0] MEM_BYTES = (XLEN+1)'(4 * MEM_WORDS);
  localparam logic [31:0]   NOP       = 32'h0000_0013;

  typedef enum logic {S_FETCH, S_HALT} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0]     r_mem [MEM_WORDS];
  logic [XLEN-1:0] r_pc;
  logic            r_infl;
  logic            r_infl_fault;
  logic [XLEN-1:0] r_infl_pc;
  logic [31:0]     r_rdata;

  logic [XLEN-1:0] r_fq_pc    [FIFO_DEPTH];
  logic [31:0]     r_fq_instr [FIFO_DEPTH];
  logic            r_fq_fault [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_pc_fault, w_ld_ok, w_valid, w_pop, w_issue;
  logic [CW:0]     w_occ;
  logic            w_unused;

  assign w_unused   = &{1'b0, bus.load_addr[1:0]};
  assign w_pc_fault = (r_pc[1:0] != 2'b00) || ({1'b0, r_pc} >= MEM_BYTES);
  assign w_ld_ok    = ({1'b0, bus.load_addr} < MEM_BYTES);
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & bus.out_ready;
  // Occupancy the issued word will see when it lands: reserves a slot for the in-flight read.
  assign w_occ      = {1'b0, r_count} - (CW+1)'(w_pop) + (CW+1)'(r_infl);
  assign w_issue    = (r_state == S_FETCH) && !bus.redirect_valid &&
                      (w_occ < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    if (bus.redirect_valid)        w_state_nxt = S_FETCH;
    else if (w_issue && w_pc_fault) w_state_nxt = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // Read and write in one always_ff so a same-word collision returns the old data.
  always_ff @(posedge clk) begin
    if (bus.load_en && w_ld_ok) r_mem[bus.load_addr[AW+1:2]] <= bus.load_data;
    if (w_issue && !w_pc_fault) r_rdata <= r_mem[r_pc[AW+1:2]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_infl       <= 1'b0;
      r_infl_pc    <= '0;
      r_infl_fault <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pc   <= bus.redirect_pc;
      r_infl <= 1'b0;
    end else begin
      r_infl <= w_issue;
      if (w_issue) begin
        r_infl_pc    <= r_pc;
        r_infl_fault <= w_pc_fault;
        r_pc         <= r_pc + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (r_infl) begin
        r_fq_pc[r_wptr]    <= r_infl_pc;
        r_fq_instr[r_wptr] <= r_infl_fault ? NOP : r_rdata;
        r_fq_fault[r_wptr] <= r_infl_fault;
        r_wptr             <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(r_infl) - CW'(w_pop);
    end
  end

  assign bus.out_valid = w_valid;
  assign bus.out_pc    = w_valid ? r_fq_pc[r_rptr]    : '0;
  assign bus.out_instr = w_valid ? r_fq_instr[r_rptr] : '0;
  assign bus.out_fault = w_valid ? r_fq_fault[r_rptr] : 1'b0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: latency, backpressure, redirect, faults, preload, reset.
module tb_instr_fetch_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_queue_if #(.XLEN(32)) bus ();

  instr_fetch_queue #(
    .XLEN(32), .MEM_WORDS(256), .FIFO_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic f);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_pc"}, bus.out_pc, pc);
    chk({tag, "_fault"}, {31'd0, bus.out_fault}, {31'd0, f});
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
    tick();
    ld(32'h0, 32'h0000_0013);
    ld(32'h4, 32'h0050_0093);
    ld(32'h8, 32'h0010_8133);
    ld(32'h3FC, 32'hCAFE_0FFF);
    ld(32'h400, 32'hFFFF_FFFF);   // out of range: must not alias word 0
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_fault", {31'd0, bus.out_fault}, 32'd0);

    // sequential fetch, first valid two edges after reset release
    reset = 1'b0; bus.out_ready = 1'b1;
    tick(); chk("t1_lat", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk_head("t1_h0", 32'h0, 1'b0); chk("t1_i0", bus.out_instr, 32'h0000_0013);
    tick(); chk_head("t1_h1", 32'h4, 1'b0); chk("t1_i1", bus.out_instr, 32'h0050_0093);
    tick(); chk_head("t1_h2", 32'h8, 1'b0); chk("t1_i2", bus.out_instr, 32'h0010_8133);

    // backpressure from a fresh start at pc 0
    bus.out_ready = 1'b0;
    redirect(32'h0);
    chk("t2_flush", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk("t2_lat", {31'd0, bus.out_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick(); chk_head("t2_hold", 32'h0, 1'b0);
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(); chk_head("t2_drain", 32'(4 * i), 1'b0);
    end

    // redirect with 3 queued entries and a read in flight
    redirect(32'h20);
    chk("t3_flush", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk("t3_lat", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk_head("t3_h0", 32'h20, 1'b0);
    tick(); chk_head("t3_h1", 32'h24, 1'b0);

    // last word then out-of-range fault and halt
    redirect(32'h3FC);
    chk("t4_flush", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk("t4_lat", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk_head("t4_last", 32'h3FC, 1'b0); chk("t4_ilast", bus.out_instr, 32'hCAFE_0FFF);
    tick(); chk_head("t4_oor", 32'h400, 1'b1); chk("t4_inop", bus.out_instr, 32'h0000_0013);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("t4_halt", {31'd0, bus.out_valid}, 32'd0);
    end

    // misaligned fault, halt, then resume
    redirect(32'h6);
    tick();
    tick(); chk_head("t5_mis", 32'h6, 1'b1); chk("t5_inop", bus.out_instr, 32'h0000_0013);
    tick(); chk("t5_halt0", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk("t5_halt1", {31'd0, bus.out_valid}, 32'd0);
    redirect(32'h0);
    tick();
    tick(); chk_head("t5_res0", 32'h0, 1'b0); chk("t5_ires0", bus.out_instr, 32'h0000_0013);

    // write word 8 in the cycle it is issued: old data delivered
    bus.load_en = 1'b1; bus.load_addr = 32'h8; bus.load_data = 32'hDEAD_BEEF;
    tick(); bus.load_en = 1'b0;
    chk_head("t6_h4", 32'h4, 1'b0); chk("t6_i4", bus.out_instr, 32'h0050_0093);
    tick(); chk_head("t6_h8", 32'h8, 1'b0); chk("t6_old", bus.out_instr, 32'h0010_8133);
    redirect(32'h8);
    tick();
    tick(); chk_head("t6_re8", 32'h8, 1'b0); chk("t6_new", bus.out_instr, 32'hDEAD_BEEF);
    tick(); chk_head("t6_reC", 32'hC, 1'b0);

    // reset mid-stream
    reset = 1'b1;
    tick(); chk("t6_rst_v", {31'd0, bus.out_valid}, 32'd0); chk("t6_rst_pc", bus.out_pc, 32'h0);
    reset = 1'b0;
    tick(); chk("t6_rst_lat", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk_head("t6_rst_h0", 32'h0, 1'b0); chk("t6_rst_i0", bus.out_instr, 32'h0000_0013);
    tick(); chk_head("t6_rst_h1", 32'h4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
